// File: rtl/sdes_pkg.sv
// rtl/sdes_pkg.sv - S-DES tables, FSM state codes and permutation/key-schedule helpers
// All tables are 1-based position lists; vectors use ascending [0:N] ranges so
// that bit 0 is table position 1.
package sdes_pkg;

  localparam int P10_TBL [0:9] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_TBL  [0:7] = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int IP_TBL  [0:7] = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int IPI_TBL [0:7] = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int EP_TBL  [0:7] = '{4, 1, 2, 3, 2, 3, 4, 1};
  localparam int P4_TBL  [0:3] = '{2, 4, 3, 1};

  localparam logic [1:0] S0_TBL [0:3][0:3] = '{
    '{2'd1, 2'd0, 2'd3, 2'd2},
    '{2'd3, 2'd2, 2'd1, 2'd0},
    '{2'd0, 2'd2, 2'd1, 2'd3},
    '{2'd3, 2'd1, 2'd3, 2'd2}
  };
  localparam logic [1:0] S1_TBL [0:3][0:3] = '{
    '{2'd0, 2'd1, 2'd2, 2'd3},
    '{2'd2, 2'd0, 2'd1, 2'd3},
    '{2'd3, 2'd0, 2'd1, 2'd0},
    '{2'd2, 2'd1, 2'd0, 2'd3}
  };

  // FSM state enumeration (plain codes for compatibility with older tools)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_KEYGEN = 3'd1;
  localparam state_t ST_RND_K2 = 3'd2;
  localparam state_t ST_SWAP   = 3'd3;
  localparam state_t ST_RND_K1 = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  function automatic logic [0:9] perm_p10(input logic [0:9] d);
    logic [0:9] r;
    for (int i = 0; i < 10; i++) r[i] = d[P10_TBL[i] - 1];
    return r;
  endfunction

  function automatic logic [0:7] perm_p8(input logic [0:9] d);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = d[P8_TBL[i] - 1];
    return r;
  endfunction

  function automatic logic [0:7] perm_ip(input logic [0:7] d);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = d[IP_TBL[i] - 1];
    return r;
  endfunction

  function automatic logic [0:7] perm_ip_inv(input logic [0:7] d);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = d[IPI_TBL[i] - 1];
    return r;
  endfunction

  function automatic logic [0:7] perm_ep(input logic [0:3] d);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = d[EP_TBL[i] - 1];
    return r;
  endfunction

  function automatic logic [0:3] perm_p4(input logic [0:3] d);
    logic [0:3] r;
    for (int i = 0; i < 4; i++) r[i] = d[P4_TBL[i] - 1];
    return r;
  endfunction

  // Row is taken from the outer bits (1,4), column from the inner bits (2,3)
  function automatic logic [1:0] sbox0(input logic [0:3] d);
    return S0_TBL[{d[0], d[3]}][{d[1], d[2]}];
  endfunction

  function automatic logic [1:0] sbox1(input logic [0:3] d);
    return S1_TBL[{d[0], d[3]}][{d[1], d[2]}];
  endfunction

  // K1 uses a 1-bit left rotate of each P10 half; K2 a further 2 bits (3 total)
  function automatic logic [0:7] gen_k1(input logic [0:9] key);
    logic [0:9] p;
    p = perm_p10(key);
    return perm_p8({p[1:4], p[0], p[6:9], p[5]});
  endfunction

  function automatic logic [0:7] gen_k2(input logic [0:9] key);
    logic [0:9] p;
    p = perm_p10(key);
    return perm_p8({p[3:4], p[0:2], p[8:9], p[5:7]});
  endfunction

endpackage

// File: rtl/sdes_fk.sv
// rtl/sdes_fk.sv - combinational S-DES round function fK
// Ports:
//   data   [0:7] in  : L (bits 0-3) and R (bits 4-7)
//   subkey [0:7] in  : round subkey
//   result [0:7] out : {L xor F(R, subkey), R}
module sdes_fk (
  input  logic [0:7] data,
  input  logic [0:7] subkey,
  output logic [0:7] result
);
  import sdes_pkg::*;

  logic [0:7] ep_x;
  logic [0:3] sbox_out;

  assign ep_x     = perm_ep(data[4:7]) ^ subkey;
  assign sbox_out = {sbox0(ep_x[0:3]), sbox1(ep_x[4:7])};
  assign result   = {data[0:3] ^ perm_p4(sbox_out), data[4:7]};

endmodule

// File: rtl/sdes_decrypt_seq.sv
// rtl/sdes_decrypt_seq.sv - sequential S-DES decryptor, one job at a time
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : job handshake for cipher_in [0:7] and key_in [0:9]
//   out_valid/out_ready: result handshake for plain_out [0:7]
//   busy               : high whenever a job is in flight or awaiting pickup
module sdes_decrypt_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [0:7] cipher_in,
  input  logic [0:9] key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [0:7] plain_out,
  output logic       busy
);
  import sdes_pkg::*;

  state_t     state;
  logic [0:9] key_reg;
  logic [0:7] data_reg;
  logic [0:7] k1_reg;
  logic [0:7] k2_reg;
  logic [0:7] plain_reg;
  logic [0:7] fk_key;
  logic [0:7] fk_out;

  // One fK instance serves both rounds; only the subkey changes
  assign fk_key = (state == ST_RND_K2) ? k2_reg : k1_reg;

  sdes_fk u_fk (
    .data   (data_reg),
    .subkey (fk_key),
    .result (fk_out)
  );

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign plain_out = plain_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      key_reg   <= '0;
      data_reg  <= '0;
      k1_reg    <= '0;
      k2_reg    <= '0;
      plain_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            key_reg  <= key_in;
            data_reg <= perm_ip(cipher_in);
            state    <= ST_KEYGEN;
          end
        end
        ST_KEYGEN: begin
          k1_reg <= gen_k1(key_reg);
          k2_reg <= gen_k2(key_reg);
          state  <= ST_RND_K2;
        end
        ST_RND_K2: begin
          data_reg <= fk_out;
          state    <= ST_SWAP;
        end
        ST_SWAP: begin
          data_reg <= {data_reg[4:7], data_reg[0:3]};
          state    <= ST_RND_K1;
        end
        ST_RND_K1: begin
          data_reg  <= fk_out;
          plain_reg <= perm_ip_inv(fk_out);
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
